// File: rtl/pc_fetch_control_pkg.sv
// Shared definitions for the fetch-stage PC controller: FSM encodings,
// the default HALT word and the sequential PC increment.
package pc_fetch_control_pkg;

  typedef enum logic [1:0] {
    ST_IDLE   = 2'b00,
    ST_RUN    = 2'b01,
    ST_HALTED = 2'b10
  } fetch_state_e;

  localparam logic [31:0] HALT_OPCODE_DEFAULT = 32'hFFFF_FFFF;
  localparam int unsigned PC_INCREMENT        = 4;

endpackage

// File: rtl/pc_next_select.sv
// Next-PC selection: jump beats branch beats sequential, with redirect
// targets forced onto a word boundary.
module pc_next_select
  import pc_fetch_control_pkg::*;
#(
  parameter int NB = 32
) (
  input  logic [NB-1:0] i_pc,
  input  logic          i_jump,
  input  logic [NB-1:0] i_jump_target,
  input  logic          i_branch_taken,
  input  logic [NB-1:0] i_branch_target,
  output logic [NB-1:0] o_next_pc,
  output logic [NB-1:0] o_pc_plus_4
);

  localparam logic [NB-1:0] ALIGN_MASK = ~NB'(3);

  // Sequential increment wraps naturally at 2^NB.
  assign o_pc_plus_4 = i_pc + NB'(PC_INCREMENT);

  always_comb begin
    o_next_pc = o_pc_plus_4;
    if (i_jump) begin
      o_next_pc = i_jump_target & ALIGN_MASK;
    end else if (i_branch_taken) begin
      o_next_pc = i_branch_target & ALIGN_MASK;
    end
  end

endmodule

// File: rtl/pc_fetch_control.sv
// Fetch-stage program counter and run controller: IDLE/RUN/HALTED FSM,
// continuous or single-step fetch, hazard stalls and HALT detection.
module pc_fetch_control
  import pc_fetch_control_pkg::*;
#(
  parameter int            NB                = 32,
  parameter int            N_OF_INSTRUCTIONS = 64,
  parameter logic [NB-1:0] RESET_PC          = '0,
  parameter logic [NB-1:0] HALT_OPCODE       = HALT_OPCODE_DEFAULT[NB-1:0]
) (
  input  logic          i_clock,
  input  logic          i_reset,
  input  logic          i_start,
  input  logic          i_step_mode,
  input  logic          i_step,
  input  logic          i_stall,
  input  logic          i_jump,
  input  logic [NB-1:0] i_jump_target,
  input  logic          i_branch_taken,
  input  logic [NB-1:0] i_branch_target,
  input  logic [NB-1:0] i_instruction,
  output logic [NB-1:0] o_pc,
  output logic [NB-1:0] o_pc_plus_4,
  output logic          o_pc_valid,
  output logic          o_halted,
  output logic [1:0]    o_state,
  output logic [NB-1:0] o_cycle_count
);

  localparam logic [NB:0] PC_LIMIT = (NB+1)'(PC_INCREMENT * N_OF_INSTRUCTIONS);

  fetch_state_e  state_q, state_d;
  logic [NB-1:0] pc_q, pc_d;
  logic [NB-1:0] cycleCount_q, cycleCount_d;
  logic          step_q;

  logic [NB-1:0] nextPc;
  logic          stepPulse;
  logic          advance;
  logic          isHalt;
  logic          outOfRange;
  logic          pcLoad;

  pc_next_select #(
    .NB(NB)
  ) u_next_select (
    .i_pc            (pc_q),
    .i_jump          (i_jump),
    .i_jump_target   (i_jump_target),
    .i_branch_taken  (i_branch_taken),
    .i_branch_target (i_branch_target),
    .o_next_pc       (nextPc),
    .o_pc_plus_4     (o_pc_plus_4)
  );

  assign stepPulse  = i_step & ~step_q;
  assign isHalt     = (i_instruction == HALT_OPCODE);
  assign outOfRange = ({1'b0, nextPc} >= PC_LIMIT);

  always_ff @(posedge i_clock) begin
    if (i_reset) begin
      state_q <= ST_IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      ST_IDLE:   if (i_start) state_d = ST_RUN;
      ST_RUN:    if (advance && (isHalt || outOfRange)) state_d = ST_HALTED;
      ST_HALTED: state_d = ST_HALTED;
      default:   state_d = ST_IDLE;
    endcase
  end

  // A stall suppresses the advance entirely, so redirects in that cycle are lost.
  always_comb begin
    advance    = (state_q == ST_RUN) && !i_stall && (!i_step_mode || stepPulse);
    pcLoad     = advance && !isHalt && !outOfRange;
    o_pc_valid = advance;
    o_halted   = (state_q == ST_HALTED);
    o_state    = state_q;
  end

  always_comb begin
    pc_d         = pcLoad ? nextPc : pc_q;
    cycleCount_d = cycleCount_q;
    if (state_q == ST_RUN && cycleCount_q != '1) begin
      cycleCount_d = cycleCount_q + NB'(1);
    end
  end

  always_ff @(posedge i_clock) begin
    if (i_reset) begin
      pc_q         <= RESET_PC;
      cycleCount_q <= '0;
      step_q       <= 1'b0;
    end else begin
      pc_q         <= pc_d;
      cycleCount_q <= cycleCount_d;
      step_q       <= i_step;
    end
  end

  assign o_pc          = pc_q;
  assign o_cycle_count = cycleCount_q;

endmodule
